dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Handshaked data-memory responder that serves load/store requests from the RISC-V core's memory stage. It is the target side of the core's data-memory port and replaces the single-cycle array with a multi-cycle slave: request in, fixed-latency response out. It handles byte/halfword/word sizing, lane alignment and load sign/zero extension, so the core only sends raw address, store data and FUNC3.

Parameters:
ADDR_W, 10, word-address bits; depth = 2**ADDR_W 32-bit words
LATENCY, 2, cycles from request acceptance to response; legal range 1..15

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
REQ_VALID  in  1  request present
REQ_READY  out  1  responder can accept a request
REQ_WE  in  1  1 = store, 0 = load
REQ_FUNC3  in  3  RISC-V load/store funct3
REQ_ADDR  in  32  byte address
REQ_WDATA  in  32  store data, right-aligned
RSP_VALID  out  1  one-cycle response strobe
RSP_RDATA  out  32  extended load data; 0 for stores and errors
RSP_ERR  out  1  access rejected, qualified by RSP_VALID

Behaviour:
- Clock CLK; reset RESET is asynchronous and active-high.
- Reset values: state IDLE, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0. REQ_READY=0 while RESET is high. Memory array is not cleared.
- FSM states:
  - IDLE: REQ_READY=1. On REQ_VALID&REQ_READY at edge E0, capture WE/FUNC3/ADDR/WDATA, load cnt=LATENCY-1, go to WAIT.
  - WAIT: REQ_READY=0. If cnt!=0, decrement. If cnt==0, perform the access and go to RESP.
  - RESP: RSP_VALID=1 for exactly one cycle, beginning at edge E0+LATENCY. Then return to IDLE.
- Throughput: one request per LATENCY+1 cycles. There is no response backpressure; the core must stall until RSP_VALID.
- Word index is ADDR[ADDR_W+1:2]. Higher address bits are ignored, so addresses alias modulo the depth.
- Byte lane is ADDR[1:0].
- Stores:
  - SB (000): writes byte lane ADDR[1:0] with WDATA[7:0].
  - SH (001): writes the halfword at lane ADDR[1] with WDATA[15:0].
  - SW (010): writes the full word.
  - Unwritten bytes are preserved. RSP_RDATA=0.
- Loads: LB (000) and LH (001) sign-extend; LW (010) is a full word; LBU (100) and LHU (101) zero-extend.
- Illegal FUNC3 (load 011/110/111, store 011-111) always produces RSP_ERR=1, no write, RSP_RDATA=0.
- RSP_RDATA and RSP_ERR are registered on entry to RESP. They hold their values until the next RESP entry.
- REQ_* inputs are ignored outside IDLE. Captured values are unaffected by input changes during WAIT.
- Reset during WAIT or RESP: return to IDLE immediately. A pending store is dropped (it never reaches the array) and no response is issued.
- Back-to-back store then load to the same word: the load returns the stored data, because accesses are fully serialized.

Optional Feature:
MISALIGN_CHECK_EN
- Defined: an LH/LHU/SH with ADDR[0]=1, or an LW/SW with ADDR[1:0]!=0, is rejected. There is no write, RSP_RDATA=0, RSP_ERR=1, and latency is unchanged.
- Undefined: low address bits are silently masked. Halfword accesses use ADDR[1] only; word accesses ignore ADDR[1:0]. RSP_ERR is asserted only for illegal FUNC3.

Decomposition:
- Shared package holds:
  - FUNC3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - state encoding ST_IDLE/ST_WAIT/ST_RESP
  - the LATENCY counter width (4 bits)
- Natural sub-module dmem_lane_align, purely combinational. It takes FUNC3, ADDR[1:0], WDATA and the read word, and produces:
  - 4-bit byte enable
  - shifted write data
  - extended load data
  - misalign and illegal flags
- The top level keeps the FSM, counter, capture registers and array.

Test Plan:
1. Reset, then SW addr 0x10 data 0xDEADBEEF, then LW 0x10 (LATENCY=2) -> RSP_VALID exactly 2 cycles after each accept; second response RSP_RDATA=0xDEADBEEF, RSP_ERR=0.
2. SB 0x13 data 0x80, then LB 0x13 and LBU 0x13 -> word at 0x10 reads 0x80ADBEEF; LB returns 0xFFFFFF80, LBU returns 0x00000080.
3. SH 0x12 data 0x1234, then LH 0x12 and LHU 0x12 -> 0x00001234 for both; bytes 0x10-0x11 unchanged (0xBEEF).
4. LW 0x11 -> with MISALIGN_CHECK_EN: RSP_ERR=1, RSP_RDATA=0; without: RSP_RDATA = word at 0x10, RSP_ERR=0.
5. Load with FUNC3=011 -> RSP_ERR=1, RSP_RDATA=0; SB with FUNC3=111 -> RSP_ERR=1, memory unchanged.
6. SW 0x20 data 0x55 with RESET pulsed during WAIT, then LW 0x20 -> no RSP_VALID for the store; load returns prior contents, not 0x55; REQ_READY=0 during reset.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// ----------------------------------------------------------------------------
// dmem_responder_pkg
// Shared definitions for the data-memory responder and its lane aligner:
//   - RISC-V load/store FUNC3 codes
//   - responder FSM state encoding
//   - width of the latency down-counter
//   - helper that decides whether a FUNC3 is a legal load or store
// No ports (package).
// ----------------------------------------------------------------------------
package dmem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Wide enough for LATENCY-1 with LATENCY up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Stores only exist in byte/half/word flavours; loads also have the
    // unsigned byte/half variants.
    function automatic logic isLegalFunc3(input logic i_we, input logic [2:0] i_func3);
        logic w_legal;
        w_legal = 1'b0;
        if (i_we) begin
            w_legal = (i_func3 == F3_B) || (i_func3 == F3_H) || (i_func3 == F3_W);
        end else begin
            w_legal = (i_func3 == F3_B)  || (i_func3 == F3_H)  || (i_func3 == F3_W) ||
                      (i_func3 == F3_BU) || (i_func3 == F3_HU);
        end
        return w_legal;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// ----------------------------------------------------------------------------
// dmem_responder_if
// Request/response bundle between the core's memory stage (master) and the
// data-memory responder (slave).
//   REQ_VALID  master->slave  request present
//   REQ_READY  slave->master  responder can accept a request
//   REQ_WE     master->slave  1 = store, 0 = load
//   REQ_FUNC3  master->slave  RISC-V load/store funct3
//   REQ_ADDR   master->slave  byte address
//   REQ_WDATA  master->slave  store data, right-aligned
//   RSP_VALID  slave->master  one-cycle response strobe
//   RSP_RDATA  slave->master  extended load data (0 for stores/errors)
//   RSP_ERR    slave->master  access rejected, qualified by RSP_VALID
// ----------------------------------------------------------------------------
interface dmem_responder_if;

    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WE;
    logic [2:0]  REQ_FUNC3;
    logic [31:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic        RSP_VALID;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;

    modport master (
        output REQ_VALID, REQ_WE, REQ_FUNC3, REQ_ADDR, REQ_WDATA,
        input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
    );

    modport slave (
        input  REQ_VALID, REQ_WE, REQ_FUNC3, REQ_ADDR, REQ_WDATA,
        output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
    );

endinterface

// File: rtl/dmem_lane_align.sv
// ----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational lane steering for the data-memory responder.
// Ports:
//   i_we        1 = store, 0 = load
//   i_func3     RISC-V load/store funct3
//   i_addrLo    byte lane (ADDR[1:0])
//   i_wdata     right-aligned store data
//   i_rword     32-bit word read from the array
//   o_byteEn    per-byte write enable for the addressed word
//   o_wdata     store data replicated onto the lanes it may hit
//   o_rdata     sign/zero extended load data
//   o_misalign  halfword/word access not naturally aligned
//   o_illegal   FUNC3 is not a legal load/store encoding
// Build option: MISALIGN_CHECK_EN -- when defined, o_misalign flags
// misaligned halfword/word accesses; otherwise it stays 0 and the low
// address bits are simply masked.
// ----------------------------------------------------------------------------
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic        i_we,
    input  logic [2:0]  i_func3,
    input  logic [1:0]  i_addrLo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_byteEn,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign,
    output logic        o_illegal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte and halfword out of the read word; halfwords
    // only look at ADDR[1], so an odd address lands on its enclosing half.
    always_comb begin
        w_byte = 8'h00;
        case (i_addrLo)
            2'd0:    w_byte = i_rword[7:0];
            2'd1:    w_byte = i_rword[15:8];
            2'd2:    w_byte = i_rword[23:16];
            default: w_byte = i_rword[31:24];
        endcase
        w_half = i_addrLo[1] ? i_rword[31:16] : i_rword[15:0];
    end

    // Size decode: byte enables and replicated store data for the write
    // path, extension for the load path. Unsigned codes never write.
    always_comb begin
        o_byteEn = 4'b0000;
        o_wdata  = 32'h0000_0000;
        o_rdata  = 32'h0000_0000;
        case (i_func3)
            F3_B: begin
                o_byteEn = 4'b0001 << i_addrLo;
                o_wdata  = {4{i_wdata[7:0]}};
                o_rdata  = {{24{w_byte[7]}}, w_byte};
            end
            F3_H: begin
                o_byteEn = i_addrLo[1] ? 4'b1100 : 4'b0011;
                o_wdata  = {2{i_wdata[15:0]}};
                o_rdata  = {{16{w_half[15]}}, w_half};
            end
            F3_W: begin
                o_byteEn = 4'b1111;
                o_wdata  = i_wdata;
                o_rdata  = i_rword;
            end
            F3_BU: begin
                o_rdata = {24'h00_0000, w_byte};
            end
            F3_HU: begin
                o_rdata = {16'h0000, w_half};
            end
            default: begin
                o_byteEn = 4'b0000;
            end
        endcase
    end

    // Misalignment only matters for halfword and word sizes.
    always_comb begin
        o_misalign = 1'b0;
`ifdef MISALIGN_CHECK_EN
        case (i_func3)
            F3_H, F3_HU: o_misalign = i_addrLo[0];
            F3_W:        o_misalign = |i_addrLo;
            default:     o_misalign = 1'b0;
        endcase
`endif
        o_illegal = !isLegalFunc3(i_we, i_func3);
    end

endmodule

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Fixed-latency, handshaked data-memory slave for the core's memory stage.
// A request is accepted in IDLE, held for LATENCY cycles, then the access is
// performed and a one-cycle response strobe is issued.
// Parameters:
//   ADDR_W   word-address bits, depth = 2**ADDR_W 32-bit words
//   LATENCY  cycles from acceptance to RSP_VALID (1..15)
// Ports:
//   CLK      rising-edge clock
//   RESET    asynchronous active-high reset
//   bus      dmem_responder_if.slave (REQ_* in, REQ_READY/RSP_* out)
// Build option: MISALIGN_CHECK_EN -- rejects misaligned halfword/word
// accesses with RSP_ERR instead of masking the low address bits.
// ----------------------------------------------------------------------------
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
)(
    input  logic             CLK,
    input  logic             RESET,
    dmem_responder_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_we;
    logic [2:0]          r_func3;
    logic [ADDR_W+1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_rspValid;
    logic [31:0]         r_rspRdata;
    logic                r_rspErr;
    logic [31:0]         r_mem [0:(1<<ADDR_W)-1];

    logic [ADDR_W-1:0]   w_wordIdx;
    logic [31:0]         w_rword;
    logic [3:0]          w_byteEn;
    logic [31:0]         w_wdataAligned;
    logic [31:0]         w_loadData;
    logic                w_misalign;
    logic                w_illegal;
    logic                w_reject;
    logic                w_doAccess;
    logic                w_doWrite;
    logic                w_unusedAddr;

    // Address bits above the array alias away.
    assign w_unusedAddr = ^bus.REQ_ADDR[31:ADDR_W+2];

    assign w_wordIdx  = r_addr[ADDR_W+1:2];
    assign w_rword    = r_mem[w_wordIdx];
    assign w_reject   = w_illegal | w_misalign;
    assign w_doAccess = (r_state == ST_WAIT) && (r_cnt == '0);
    assign w_doWrite  = w_doAccess && r_we && !w_reject;

    // Ready is simply "sitting in IDLE", forced low while reset is held.
    assign bus.REQ_READY = (r_state == ST_IDLE) && !RESET;
    assign bus.RSP_VALID = r_rspValid;
    assign bus.RSP_RDATA = r_rspRdata;
    assign bus.RSP_ERR   = r_rspErr;

    dmem_lane_align u_laneAlign (
        .i_we       (r_we),
        .i_func3    (r_func3),
        .i_addrLo   (r_addr[1:0]),
        .i_wdata    (r_wdata),
        .i_rword    (w_rword),
        .o_byteEn   (w_byteEn),
        .o_wdata    (w_wdataAligned),
        .o_rdata    (w_loadData),
        .o_misalign (w_misalign),
        .o_illegal  (w_illegal)
    );

    // Request FSM. Inputs are captured once in IDLE and never sampled again
    // until the next IDLE, so the core may change them freely while we wait.
    // The response data/error are loaded on the edge into RESP and then held
    // until the next response, so they stay readable after the strobe.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_func3    <= 3'b000;
            r_addr     <= '0;
            r_wdata    <= 32'h0000_0000;
            r_rspValid <= 1'b0;
            r_rspRdata <= 32'h0000_0000;
            r_rspErr   <= 1'b0;
        end else begin
            r_rspValid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.REQ_VALID) begin
                        r_we    <= bus.REQ_WE;
                        r_func3 <= bus.REQ_FUNC3;
                        r_addr  <= bus.REQ_ADDR[ADDR_W+1:0];
                        r_wdata <= bus.REQ_WDATA;
                        r_cnt   <= CNT_INIT;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state    <= ST_RESP;
                        r_rspValid <= 1'b1;
                        r_rspErr   <= w_reject;
                        r_rspRdata <= (r_we || w_reject) ? 32'h0000_0000 : w_loadData;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Byte-enabled array write on the same edge the FSM enters RESP. The
    // array has no reset; a reset in WAIT pulls the FSM out asynchronously,
    // so a pending store never gets here.
    always_ff @(posedge CLK) begin
        if (w_doWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (w_byteEn[b]) begin
                    r_mem[w_wordIdx][b*8 +: 8] <= w_wdataAligned[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
// Randomized and directed self-checking bench for dmem_responder.
// A byte-addressed reference memory predicts every response; a monitor
// compares the DUT outputs against the predicted responses on every cycle.
// Build option: MISALIGN_CHECK_EN changes the expected results for
// misaligned halfword/word accesses.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int LAT    = 2;
    localparam int ADDR_W = 10;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    dmem_responder_if bus ();

    dmem_responder #(
        .ADDR_W  (ADDR_W),
        .LATENCY (LAT)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        expQ[$];
    int          cyc         = 0;
    int          nCompared   = 0;
    int          nMismatched = 0;
    logic [7:0]  refMem[64];
    logic [31:0] heldRdata   = 32'h0;
    logic        heldErr     = 1'b0;
    logic [31:0] lastRdata   = 32'h0;
    logic        lastErr     = 1'b0;

    // One comparison: counts it, and reports a failure with both values.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour: byte-addressed memory, bench-only window of 64
    // bytes. Higher address bits alias, so only ADDR[5:0] matters here.
    function automatic void modelAccess(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                        input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int a;
        int h;
        int w;
        bit legal;
        bit mis;
        a = int'(addr[5:0]);
        h = a - (a % 2);
        w = a - (a % 4);
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis = 1'b0;
`ifdef MISALIGN_CHECK_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2) != 0) mis = 1'b1;
        if (f3 == 3'd2 && (a % 4) != 0) mis = 1'b1;
`endif
        rd  = 32'h0;
        err = !legal || mis;
        if (err) return;
        if (we) begin
            case (f3)
                3'd0: refMem[a] = wd[7:0];
                3'd1: begin refMem[h] = wd[7:0]; refMem[h+1] = wd[15:8]; end
                default: begin
                    refMem[w]   = wd[7:0];   refMem[w+1] = wd[15:8];
                    refMem[w+2] = wd[23:16]; refMem[w+3] = wd[31:24];
                end
            endcase
        end else begin
            case (f3)
                3'd0: rd = int'($signed(refMem[a]));
                3'd4: rd = int'(refMem[a]);
                3'd1: rd = int'($signed({refMem[h+1], refMem[h]}));
                3'd5: rd = int'({refMem[h+1], refMem[h]});
                default: rd = {refMem[w+3], refMem[w+2], refMem[w+1], refMem[w]};
            endcase
        end
    endfunction

    // Monitor: every cycle, #1 after the rising edge, the outputs must be
    // either the predicted response (on its due cycle) or the held values.
    initial begin
        forever begin
            @(posedge CLK);
            cyc++;
            #1;
            if (RESET) begin
                checkOutput("ready_in_reset", {31'b0, bus.REQ_READY}, 32'd0);
                checkOutput("valid_in_reset", {31'b0, bus.RSP_VALID}, 32'd0);
                checkOutput("rdata_in_reset", bus.RSP_RDATA, 32'd0);
                checkOutput("err_in_reset",   {31'b0, bus.RSP_ERR},   32'd0);
                heldRdata = 32'h0;
                heldErr   = 1'b0;
                expQ.delete();
            end else begin
                if (expQ.size() > 0 && expQ[0].due < cyc) begin
                    checkOutput("missed_response_due", cyc, expQ[0].due);
                    void'(expQ.pop_front());
                end
                if (expQ.size() > 0 && expQ[0].due == cyc) begin
                    checkOutput("rsp_valid", {31'b0, bus.RSP_VALID}, 32'd1);
                    checkOutput("rsp_rdata", bus.RSP_RDATA, expQ[0].rdata);
                    checkOutput("rsp_err",   {31'b0, bus.RSP_ERR}, {31'b0, expQ[0].err});
                    heldRdata = expQ[0].rdata;
                    heldErr   = expQ[0].err;
                    lastRdata = bus.RSP_RDATA;
                    lastErr   = bus.RSP_ERR;
                    void'(expQ.pop_front());
                end else begin
                    checkOutput("rsp_valid_idle", {31'b0, bus.RSP_VALID}, 32'd0);
                    checkOutput("rdata_hold", bus.RSP_RDATA, heldRdata);
                    checkOutput("err_hold",   {31'b0, bus.RSP_ERR}, {31'b0, heldErr});
                end
            end
        end
    end

    // Issue one request, scribble on the inputs while the responder is busy,
    // then wait (bounded) for the monitor to consume the response.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd);
        int          t;
        logic [31:0] rd;
        logic        er;
        t = 0;
        @(negedge CLK);
        while (!bus.REQ_READY && t < 20) begin
            @(negedge CLK);
            t++;
        end
        if (!bus.REQ_READY) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
            return;
        end
        bus.REQ_VALID = 1'b1;
        bus.REQ_WE    = we;
        bus.REQ_FUNC3 = f3;
        bus.REQ_ADDR  = addr;
        bus.REQ_WDATA = wd;
        modelAccess(we, f3, addr, wd, rd, er);
        expQ.push_back('{cyc + 1 + LAT, rd, er});
        for (int j = 0; j <= LAT; j++) begin
            @(negedge CLK);
            bus.REQ_VALID = 1'b1;
            bus.REQ_WE    = 1'($urandom);
            bus.REQ_FUNC3 = 3'($urandom);
            bus.REQ_ADDR  = $urandom;
            bus.REQ_WDATA = $urandom;
        end
        @(negedge CLK);
        bus.REQ_VALID = 1'b0;
        t = 0;
        while (expQ.size() != 0 && t < 50) begin
            @(negedge CLK);
            t++;
        end
        if (expQ.size() != 0) begin
            checkOutput("response_timeout", 32'd0, 32'd1);
            expQ.delete();
        end
    endtask

    // A store accepted and then killed by reset while still waiting.
    task automatic applyResetDuringWait(input logic [31:0] addr, input logic [31:0] wd);
        @(negedge CLK);
        checkOutput("ready_before_reset_store", {31'b0, bus.REQ_READY}, 32'd1);
        bus.REQ_VALID = 1'b1;
        bus.REQ_WE    = 1'b1;
        bus.REQ_FUNC3 = 3'b010;
        bus.REQ_ADDR  = addr;
        bus.REQ_WDATA = wd;
        @(negedge CLK);
        bus.REQ_VALID = 1'b0;
        RESET = 1'b1;
        #1;
        checkOutput("ready_low_during_reset", {31'b0, bus.REQ_READY}, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (LAT + 3) @(negedge CLK);
    endtask

    // Main sequence: reset, preload, directed plan, random traffic.
    initial begin
        logic [31:0] rnd;
        logic [31:0] addr;
        bus.REQ_VALID = 1'b0;
        bus.REQ_WE    = 1'b0;
        bus.REQ_FUNC3 = 3'b000;
        bus.REQ_ADDR  = 32'h0;
        bus.REQ_WDATA = 32'h0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;

        for (int w = 0; w < 16; w++) begin
            applyStimulus(1'b1, 3'b010, 32'(w * 4), (w == 8) ? 32'hCAFE_F00D : $urandom);
        end

        applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        checkOutput("t1_sw_rdata", lastRdata, 32'h0);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0);
        checkOutput("t1_lw_rdata", lastRdata, 32'hDEAD_BEEF);
        checkOutput("t1_lw_err", {31'b0, lastErr}, 32'd0);

        applyStimulus(1'b1, 3'b000, 32'h13, 32'h80);
        applyStimulus(1'b0, 3'b000, 32'h13, 32'h0);
        checkOutput("t2_lb", lastRdata, 32'hFFFF_FF80);
        applyStimulus(1'b0, 3'b100, 32'h13, 32'h0);
        checkOutput("t2_lbu", lastRdata, 32'h0000_0080);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0);
        checkOutput("t2_word", lastRdata, 32'h80AD_BEEF);

        applyStimulus(1'b1, 3'b001, 32'h12, 32'h1234);
        applyStimulus(1'b0, 3'b001, 32'h12, 32'h0);
        checkOutput("t3_lh", lastRdata, 32'h0000_1234);
        applyStimulus(1'b0, 3'b101, 32'h12, 32'h0);
        checkOutput("t3_lhu", lastRdata, 32'h0000_1234);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0);
        checkOutput("t3_word", lastRdata, 32'h1234_BEEF);

        applyStimulus(1'b0, 3'b010, 32'h11, 32'h0);
`ifdef MISALIGN_CHECK_EN
        checkOutput("t4_lw_mis_rdata", lastRdata, 32'h0);
        checkOutput("t4_lw_mis_err", {31'b0, lastErr}, 32'd1);
`else
        checkOutput("t4_lw_mis_rdata", lastRdata, 32'h1234_BEEF);
        checkOutput("t4_lw_mis_err", {31'b0, lastErr}, 32'd0);
`endif

        applyStimulus(1'b0, 3'b011, 32'h10, 32'h0);
        checkOutput("t5_ld011_err", {31'b0, lastErr}, 32'd1);
        checkOutput("t5_ld011_rdata", lastRdata, 32'h0);
        applyStimulus(1'b1, 3'b111, 32'h10, 32'hFFFF_FFFF);
        checkOutput("t5_st111_err", {31'b0, lastErr}, 32'd1);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0);
        checkOutput("t5_word_unchanged", lastRdata, 32'h1234_BEEF);

        applyResetDuringWait(32'h20, 32'h55);
        applyStimulus(1'b0, 3'b010, 32'h20, 32'h0);
        checkOutput("t6_store_dropped", lastRdata, 32'hCAFE_F00D);

        for (int i = 0; i < 250; i++) begin
            rnd  = $urandom;
            addr = {rnd[31:12], 6'b000000, 6'($urandom_range(0, 63))};
            applyStimulus(1'($urandom), 3'($urandom_range(0, 7)), addr, $urandom);
        end

        repeat (4) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    // Global bound so a stuck handshake can never hang the run.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
